// File: rtl/decoder_top.sv
// ---------------------------------------------------------------------------
// decoder_top
//   Decodes 20-bit constant-weight (weight 8) codewords back to 16-bit
//   message words. Each accepted codeword is scanned LSB first over 20
//   cycles. Every set bit adds a binomial coefficient C(p,k) to a rank
//   accumulator. The low 16 bits of the rank are sent out as two bytes,
//   high byte first. A session opened by `start` ends after NUM_WORDS
//   codewords.
//
// Parameters
//   NUM_WORDS  codewords per message block (default 10)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      one-cycle pulse that opens a decode session (IDLE/DONE only)
//   cw_in      [19:0] codeword
//   cw_valid   cw_in valid
//   cw_ready   codeword accepted this cycle (WAIT_CW only)
//   msg_byte   [7:0] recovered message byte
//   msg_valid  msg_byte valid
//   msg_ready  downstream accepts msg_byte
//   cw_err     current codeword failed its weight/range check
//   done       session complete; held until the next start
//
// Build option
//   DEC_ERR_CHECK_EN  when defined, cw_err flags a final weight != 8 or a
//                     rank >= 65536. When undefined, cw_err is tied to 0.
// ---------------------------------------------------------------------------
module decoder_top #(
  parameter int NUM_WORDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] cw_in,
  input  logic        cw_valid,
  output logic        cw_ready,
  output logic [7:0]  msg_byte,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic        cw_err,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CW,
    SCAN,
    OUT_HI,
    OUT_LO,
    DONE
  } state_t;

  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS);

  // Pascal's triangle C(n,k) for n 0..19 and k 0..8, built at elaboration.
  // Entries with n < k stay zero, which is what the ranking sum needs.
  function automatic logic [19:0][8:0][16:0] build_binom();
    logic [19:0][8:0][16:0] t;
    t = '0;
    for (int n = 0; n < 20; n++) begin
      t[n][0] = 17'd1;
      if (n > 0) begin
        for (int k = 1; k < 9; k++) begin
          t[n][k] = t[n-1][k-1] + t[n-1][k];
        end
      end
    end
    return t;
  endfunction

  localparam logic [19:0][8:0][16:0] BINOM = build_binom();

  state_t           state, next_state;
  logic [19:0]      shadow;
  logic [4:0]       pos;
  logic [4:0]       k_cnt;
  logic [16:0]      rank;
  logic [WCW-1:0]   word_cnt;

  logic [4:0]       k_inc;
  logic [4:0]       k_next;
  logic [16:0]      term;
  logic [16:0]      rank_next;
  logic [WCW-1:0]   word_inc;
  logic             cw_accept;
  logic             scan_last;

  // The shadow register shifts right, so bit 0 always holds position `pos`.
  // The k counter saturates at 31. Any k above 8 contributes nothing.
  assign k_inc     = (k_cnt == 5'd31) ? k_cnt : k_cnt + 5'd1;
  assign term      = (k_inc <= 5'd8) ? BINOM[pos][k_inc[3:0]] : '0;
  assign k_next    = shadow[0] ? k_inc : k_cnt;
  assign rank_next = shadow[0] ? rank + term : rank;
  assign word_inc  = word_cnt + WCW'(1);
  assign cw_accept = (state == WAIT_CW) && cw_valid;
  assign scan_last = (state == SCAN) && (pos == 5'd19);
  assign done      = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    cw_ready   = 1'b0;
    msg_valid  = 1'b0;
    msg_byte   = '0;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = WAIT_CW;
      end
      WAIT_CW: begin
        cw_ready = 1'b1;
        if (cw_valid) next_state = SCAN;
      end
      SCAN: begin
        if (pos == 5'd19) next_state = OUT_HI;
      end
      OUT_HI: begin
        msg_valid = 1'b1;
        msg_byte  = rank[15:8];
        if (msg_ready) next_state = OUT_LO;
      end
      OUT_LO: begin
        msg_valid = 1'b1;
        msg_byte  = rank[7:0];
        if (msg_ready) next_state = (word_inc == LAST_WORD) ? DONE : WAIT_CW;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. The rank only changes in WAIT_CW and SCAN, so the output
  // bytes stay stable while the block waits on msg_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      pos      <= '0;
      k_cnt    <= '0;
      rank     <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) word_cnt <= '0;
        end
        WAIT_CW: begin
          if (cw_valid) begin
            shadow <= cw_in;
            pos    <= '0;
            k_cnt  <= '0;
            rank   <= '0;
          end
        end
        SCAN: begin
          shadow <= shadow >> 1;
          pos    <= pos + 5'd1;
          k_cnt  <= k_next;
          rank   <= rank_next;
        end
        OUT_LO: begin
          if (msg_ready) word_cnt <= word_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef DEC_ERR_CHECK_EN
  logic err_q;

  // The verdict is latched on the final scan cycle. It uses the values the
  // accumulators are about to take, and holds until the next codeword.
  always_ff @(posedge clk) begin
    if (rst)            err_q <= 1'b0;
    else if (cw_accept) err_q <= 1'b0;
    else if (scan_last) err_q <= (k_next != 5'd8) || rank_next[16];
  end

  assign cw_err = err_q;
`else
  logic unused_ok;
  assign unused_ok = cw_accept ^ scan_last;
  assign cw_err    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_top.sv
// ---------------------------------------------------------------------------
// tb_decoder_top
//   Directed self-checking bench for decoder_top (NUM_WORDS = 10).
//   Inputs change and outputs are sampled on the falling clock edge.
//   Expected bytes are hand-computed ranks:
//     000FF -> 0x0000      001FE -> 0x0008      0007F -> 0x0000 (weight 7)
//     FF000 -> 0x1EC11     00F0F -> 0x01A9      40FE0 -> 0xAE05
//   DEC_ERR_CHECK_EN selects the expected cw_err for the two bad codewords.
// ---------------------------------------------------------------------------
module tb_decoder_top;

`ifdef DEC_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] cw_in;
  logic        cw_valid;
  logic        cw_ready;
  logic [7:0]  msg_byte;
  logic        msg_valid;
  logic        msg_ready;
  logic        cw_err;
  logic        done;

  int errors = 0;
  int checks = 0;

  decoder_top #(.NUM_WORDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cw_in     (cw_in),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .msg_byte  (msg_byte),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .cw_err    (cw_err),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a falling edge. Offers cw and waits for it to be accepted.
  // Then counts cycles from the accept cycle to the first msg_valid.
  task automatic send_cw(input string tag, input logic [19:0] cw, output int lat);
    int n;
    cw_in    = cw;
    cw_valid = 1'b1;
    n = 0;
    while (!cw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_ready"}, cw_ready, 1'b1);
    @(negedge clk);
    cw_valid = 1'b0;
    cw_in    = '0;
    lat = 1;
    while (!msg_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_msg_valid"}, msg_valid, 1'b1);
  endtask

  // Call at a falling edge in OUT_HI. Optionally stalls, then takes both bytes.
  task automatic recv(input string tag, input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                      input logic exp_err, input int stall);
    check({tag, "_hi"}, msg_byte, exp_hi);
    check({tag, "_err_hi"}, cw_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      msg_ready = 1'b0;
      @(negedge clk);
      check({tag, "_stall_valid"}, msg_valid, 1'b1);
      check({tag, "_stall_byte"}, msg_byte, exp_hi);
    end
    msg_ready = 1'b1;
    @(negedge clk);
    check({tag, "_lo_valid"}, msg_valid, 1'b1);
    check({tag, "_lo"}, msg_byte, exp_lo);
    check({tag, "_err_lo"}, cw_err, exp_err);
    @(negedge clk);
    msg_ready = 1'b0;
    check({tag, "_after_valid"}, msg_valid, 1'b0);
  endtask

  logic [19:0] cw_tab   [10];
  logic [7:0]  hi_tab   [10];
  logic [7:0]  lo_tab   [10];
  logic        err_tab  [10];
  int          stall_tab[10];

  initial begin
    int lat;
    int seen;

    cw_tab    = '{20'h000FF, 20'h001FE, 20'h0007F, 20'hFF000, 20'h00F0F,
                  20'h40FE0, 20'h001FE, 20'h000FF, 20'h00F0F, 20'h40FE0};
    hi_tab    = '{8'h00, 8'h00, 8'h00, 8'hEC, 8'h01, 8'hAE, 8'h00, 8'h00, 8'h01, 8'hAE};
    lo_tab    = '{8'h00, 8'h08, 8'h00, 8'h11, 8'hA9, 8'h05, 8'h08, 8'h00, 8'hA9, 8'h05};
    err_tab   = '{1'b0, 1'b0, ERR_EN, ERR_EN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    stall_tab = '{0, 5, 0, 2, 0, 0, 0, 0, 0, 0};

    rst       = 1'b1;
    start     = 1'b0;
    cw_in     = '0;
    cw_valid  = 1'b0;
    msg_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_cw_ready",  cw_ready,  1'b0);
    check("rst_msg_valid", msg_valid, 1'b0);
    check("rst_msg_byte",  msg_byte,  8'h00);
    check("rst_cw_err",    cw_err,    1'b0);
    check("rst_done",      done,      1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cw_ready", cw_ready, 1'b0);

    // start and cw_valid together: only start counts, ready follows.
    start    = 1'b1;
    cw_valid = 1'b1;
    cw_in    = 20'h000FF;
    check("start_cyc_ready", cw_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("after_start_ready", cw_ready, 1'b1);

    // Full session of ten codewords.
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("done_before_last", done, 1'b0);
      send_cw($sformatf("w%0d", i), cw_tab[i], lat);
      check($sformatf("w%0d_latency", i), lat, 21);
      recv($sformatf("w%0d", i), hi_tab[i], lo_tab[i], err_tab[i], stall_tab[i]);
      if (i == 3) check("err_held_wait", cw_err, ERR_EN);
    end

    check("done_set",       done,     1'b1);
    check("done_cw_ready",  cw_ready, 1'b0);
    cw_valid = 1'b1;
    cw_in    = 20'h001FE;
    repeat (3) @(negedge clk);
    check("done_hold",      done,      1'b1);
    check("done_ready_low", cw_ready,  1'b0);
    check("done_no_valid",  msg_valid, 1'b0);
    cw_valid = 1'b0;

    // Restart from DONE, then reset in the middle of a scan.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_done_clr", done,     1'b0);
    check("restart_ready",    cw_ready, 1'b1);
    cw_in    = 20'h40FE0;
    cw_valid = 1'b1;
    @(negedge clk);
    cw_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midscan_cw_ready",  cw_ready,  1'b0);
    check("midscan_msg_valid", msg_valid, 1'b0);
    check("midscan_msg_byte",  msg_byte,  8'h00);
    check("midscan_cw_err",    cw_err,    1'b0);
    check("midscan_done",      done,      1'b0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (msg_valid || cw_ready) seen++;
    end
    check("post_rst_quiet", seen, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_cw("post_rst", 20'h00F0F, lat);
    check("post_rst_latency", lat, 21);
    recv("post_rst", 8'h01, 8'hA9, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_top.md
DECODER_TOP -- requirements
Module: decoder_top

Interface
REQ-001 Parameter NUM_WORDS, default 10: codewords per message block.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse that opens a decode session.
REQ-005 cw_in  input  20  constant-weight codeword, weight 8.
REQ-006 cw_valid  input  1  cw_in is valid.
REQ-007 cw_ready  output  1  block accepts cw_in this cycle.
REQ-008 msg_byte  output  8  recovered message byte.
REQ-009 msg_valid  output  1  msg_byte is valid.
REQ-010 msg_ready  input  1  downstream accepts msg_byte.
REQ-011 cw_err  output  1  current codeword failed its check.
REQ-012 done  output  1  all NUM_WORDS codewords decoded and emitted.

Function
REQ-013 States are IDLE, WAIT_CW, SCAN, OUT_HI, OUT_LO and DONE.
REQ-014 IDLE/DONE + start -> WAIT_CW, word counter cleared, done cleared; start in other states ignored.
REQ-015 WAIT_CW: cw_ready=1; cw_valid&cw_ready captures cw_in into shadow register, clears rank/count -> SCAN.
REQ-016 SCAN lasts exactly 20 cycles, position p=0..19, LSB first.
REQ-017 Each SCAN cycle with bit p set: k=k+1, then rank += C(p,k) (binomial table, n 0..19, k 1..8, 0 where p<k).
REQ-018 Rank accumulator is 17 bits wide; k counter 5 bits, saturating at 31.
REQ-019 After p=19 -> OUT_HI; latency cw accept to first msg_valid = 21 cycles.
REQ-020 OUT_HI: msg_byte=rank[15:8], msg_valid=1; msg_ready -> OUT_LO.
REQ-021 OUT_LO: msg_byte=rank[7:0], msg_valid=1; msg_ready -> increment word counter, then WAIT_CW, or DONE if counter reaches NUM_WORDS.
REQ-022 msg_byte and msg_valid stable while msg_valid=1 and msg_ready=0.
REQ-023 cw_ready=0 in every state except WAIT_CW; cw_valid outside WAIT_CW ignored.
REQ-024 msg_valid=0 in every state except OUT_HI/OUT_LO.
REQ-025 done=1 exactly while in DONE; held until next start.
REQ-026 cw_err valid during OUT_HI/OUT_LO of that codeword, cleared on next cw accept.
REQ-027 Start and cw_valid in same cycle from IDLE: only start acted on; cw_ready rises next cycle.
REQ-028 Codeword bytes emitted even when cw_err=1.

Reset
REQ-029 rst=1 at a clock edge forces IDLE from any state, including mid-SCAN or mid-output.
REQ-030 Reset values: cw_ready=0, msg_valid=0, msg_byte=0, cw_err=0, done=0, counters and rank 0.
REQ-031 Pending byte discarded on reset; no msg_valid after reset until a new codeword completes.

Configuration
REQ-032 Macro DEC_ERR_CHECK_EN defined: cw_err=1 if final k!=8 or rank[16]=1 (rank>=65536).
REQ-033 Macro DEC_ERR_CHECK_EN undefined: cw_err tied to 0, rank[16] ignored, no weight check logic; all else identical.

Verification
REQ-034 rst, start, cw_in=20'h000FF (positions 0..7) -> bytes 8'h00, 8'h00, cw_err=0, first msg_valid 21 cycles after accept.
REQ-035 cw_in=20'h001FE (positions 1..8) -> rank=C(8,8)+...+C(1,1)... = 8 -> bytes 8'h00, 8'h08.
REQ-036 Ten valid codewords, msg_ready always 1 -> 20 bytes, done=1 after 10th OUT_LO, cw_ready stays 0 afterward.
REQ-037 msg_ready held 0 for 5 cycles in OUT_HI -> msg_byte/msg_valid unchanged, no byte lost or duplicated.
REQ-038 DEC_ERR_CHECK_EN defined, cw_in=20'h0007F (weight 7) -> cw_err=1 with bytes emitted; cw_in=20'hFF000 (rank>=65536) -> cw_err=1; macro undefined -> cw_err=0 for both.
REQ-039 rst asserted at SCAN cycle 10 -> next cycle all outputs at reset values; new start plus codeword decodes correctly.
